// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the EXE-stage multiplier and divider: one request at a
// time, single-cycle start pulse, result capture/hold, flush, divide-by-zero and watchdog.
module muldiv_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic        busy,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_op_a,
  output logic [31:0] mul_op_b,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_by_zero
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [6:0]        op_q;
  logic [31:0]       src1_q, src2_q;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept, op_legal, is_mul, sel_done, sel_err, cnt_last;
  logic [31:0]       sel_result;

  assign accept   = req_valid & req_ready;
  assign op_legal = (req_op != 7'd0) && ((req_op & (req_op - 7'd1)) == 7'd0);
  assign is_mul   = |op_q[2:0];
  assign sel_done = is_mul ? mul_done : div_done;
  assign sel_err  = is_mul ? 1'b0 : div_by_zero;
  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    if (op_q[0])               sel_result = mul_product[31:0];
    else if (op_q[1] | op_q[2]) sel_result = mul_product[63:32];
    else if (op_q[3] | op_q[5]) sel_result = div_quotient;
    else                        sel_result = div_remainder;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      result_q <= 32'd0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  // Operands only change on accept, so they stay stable through LAUNCH/WAIT/DRAIN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= 7'd0;
      src1_q <= 32'd0;
      src2_q <= 32'd0;
    end else if (accept) begin
      op_q   <= req_op;
      src1_q <= req_src1;
      src2_q <= req_src2;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_legal) begin
            state_d = S_LAUNCH;
          end else begin
            state_d  = S_HOLD;
            result_d = 32'd0;
            err_d    = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        pend_d  = 1'b0;
        state_d = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (sel_done) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_HOLD;
            result_d = sel_result;
            err_d    = sel_err;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
          pend_d  = 1'b0;
        end else if (cnt_last) begin
          // The unit still owes a done; the error response waits for it.
          state_d  = S_DRAIN;
          pend_d   = 1'b1;
          result_d = 32'd0;
          err_d    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (flush) pend_d = 1'b0;
        if (sel_done) state_d = (pend_q & ~flush) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (rsp_ready | flush) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == S_IDLE) & ~flush;
    busy         = (state_q != S_IDLE);
    rsp_valid    = (state_q == S_HOLD);
    rsp_result   = result_q;
    rsp_err      = err_q;
    mul_start    = (state_q == S_LAUNCH) & ~flush & is_mul;
    div_start    = (state_q == S_LAUNCH) & ~flush & ~is_mul;
    mul_signed   = op_q[0] | op_q[1];
    div_signed   = op_q[3] | op_q[4];
    mul_op_a     = src1_q;
    mul_op_b     = src2_q;
    div_dividend = src1_q;
    div_divisor  = src2_q;
  end

endmodule
